// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the multiply-accumulate stage:
//   - state_t   : ACC (collecting terms) / HOLD (result presented)
//   - OP_W      : operand width of the multiplier core (4)
//   - PROD_W    : product width of the multiplier core (8)
//   - cnt_width : width of a counter that must hold 0..len inclusive
// -----------------------------------------------------------------------------
package mac_pkg;

    localparam int OP_W   = 4;
    localparam int PROD_W = 8;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic int cnt_width(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/mac_accumulate_stage_mult.sv
// -----------------------------------------------------------------------------
// mac_accumulate_stage_mult
// Combinational 4x4 unsigned multiplier core.
// Ports:
//   a  in  OP_W    unsigned multiplicand
//   b  in  OP_W    unsigned multiplier
//   p  out PROD_W  unsigned product a*b (0..225)
// -----------------------------------------------------------------------------
module mac_accumulate_stage_mult
    import mac_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] p
);

    assign p = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/mac_accumulate_stage.sv
// -----------------------------------------------------------------------------
// mac_accumulate_stage
// Sequential multiply-accumulate stage. Operand pairs arrive over a
// valid/ready handshake, are registered, multiplied by the 4x4 core and the
// products of LEN consecutive terms are summed into an ACC_W-bit accumulator.
// The total is then offered downstream over a second valid/ready handshake.
//
// Parameters:
//   ACC_W  accumulator/result width (8..32)
//   LEN    products per accumulation (1..255)
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   clr        in   synchronous abort, discards the partial sum
//   in_valid   in   operand pair valid
//   in_ready   out  stage can accept an operand pair (combinational)
//   x, y       in   4-bit unsigned operands
//   out_valid  out  result valid (state HOLD)
//   out_ready  in   downstream accepts the result
//   out_acc    out  accumulated sum, straight from the acc register
//   out_ovf    out  sticky overflow flag for the current accumulation
//
// Build option:
//   MAC_SATURATE_EN  defined   : an overflowing add clamps acc to 2^ACC_W-1
//                    undefined : acc wraps modulo 2^ACC_W
//   out_ovf is set on the first carry out in either build.
// -----------------------------------------------------------------------------
module mac_accumulate_stage
    import mac_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int LEN   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  x,
    input  logic [OP_W-1:0]  y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);

    localparam int                CNT_W = cnt_width(LEN);
    localparam logic [CNT_W-1:0]  LEN_C = CNT_W'(LEN);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [ACC_W-1:0]   acc_q,   acc_d;
    logic               ovf_q,   ovf_d;
    logic               v1_q,    v1_d;
    logic [OP_W-1:0]    op_x_q,  op_x_d;
    logic [OP_W-1:0]    op_y_q,  op_y_d;

    logic [PROD_W-1:0]  prod;
    logic [ACC_W:0]     sum;
    logic               accept;

    mac_accumulate_stage_mult u_mult (
        .a (op_x_q),
        .b (op_y_q),
        .p (prod)
    );

    // cnt counts accepted terms, so cnt<LEN stops intake once the last
    // term is in flight; clr blocks intake in the same cycle.
    assign in_ready  = (state_q == ACC) && (cnt_q < LEN_C) && !clr;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == HOLD);
    assign out_acc   = acc_q;
    assign out_ovf   = ovf_q;

    // One extra bit so the carry out of bit ACC_W-1 is visible.
    assign sum = {1'b0, acc_q} + (ACC_W+1)'(prod);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        v1_d    = 1'b0;
        op_x_d  = op_x_q;
        op_y_d  = op_y_q;

        if (clr) begin
            state_d = ACC;
            cnt_d   = '0;
            acc_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            if (v1_q) begin
`ifdef MAC_SATURATE_EN
                acc_d = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
                acc_d = sum[ACC_W-1:0];
`endif
                if (sum[ACC_W]) begin
                    ovf_d = 1'b1;
                end
                // v1 with cnt==LEN can only be the final term: no accept is
                // possible once cnt has reached LEN.
                if (cnt_q == LEN_C) begin
                    state_d = HOLD;
                end
            end

            if (accept) begin
                op_x_d = x;
                op_y_d = y;
                v1_d   = 1'b1;
                cnt_d  = cnt_q + 1'b1;
            end

            if ((state_q == HOLD) && out_ready) begin
                state_d = ACC;
                cnt_d   = '0;
                acc_d   = '0;
                ovf_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACC;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            v1_q    <= 1'b0;
            op_x_q  <= '0;
            op_y_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            v1_q    <= v1_d;
            op_x_q  <= op_x_d;
            op_y_q  <= op_y_d;
        end
    end

endmodule

// File: tb/tb_mac_accumulate_stage.sv
// -----------------------------------------------------------------------------
// tb_mac_accumulate_stage
// Three instances share one stimulus stream:
//   dut0: ACC_W=16, LEN=4   dut1: ACC_W=10, LEN=8   dut2: ACC_W=8, LEN=1
// Each instance has its own reference model that tracks the true arithmetic
// sum of added terms and derives the expected accumulator from it.
// -----------------------------------------------------------------------------
module tb_mac_accumulate_stage;

    localparam int NI = 3;

    int len_t[NI] = '{4, 8, 1};
    int w_t[NI]   = '{16, 10, 8};

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        in_valid;
    logic        out_ready;
    logic [3:0]  x;
    logic [3:0]  y;
    logic        rdy [NI];
    logic        vld [NI];
    logic        ovf [NI];
    logic [15:0] acc0;
    logic [9:0]  acc1;
    logic [7:0]  acc2;

    always #5 clk = ~clk;

    mac_accumulate_stage #(.ACC_W(16), .LEN(4)) u_dut0 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy[0]),
        .x(x), .y(y), .out_valid(vld[0]), .out_ready(out_ready),
        .out_acc(acc0), .out_ovf(ovf[0])
    );
    mac_accumulate_stage #(.ACC_W(10), .LEN(8)) u_dut1 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy[1]),
        .x(x), .y(y), .out_valid(vld[1]), .out_ready(out_ready),
        .out_acc(acc1), .out_ovf(ovf[1])
    );
    mac_accumulate_stage #(.ACC_W(8), .LEN(1)) u_dut2 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy[2]),
        .x(x), .y(y), .out_valid(vld[2]), .out_ready(out_ready),
        .out_acc(acc2), .out_ovf(ovf[2])
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit     m_hold  [NI];
    int     m_n     [NI];
    int     m_added [NI];
    longint m_sum   [NI];
    bit     m_pend  [NI];
    int     m_pprod [NI];
    longint cap_acc [NI];
    bit     cap_ovf [NI];
    int     hs_cnt  [NI];

    function automatic longint max_of(input int i);
        return (longint'(1) << w_t[i]) - 1;
    endfunction

    function automatic longint exp_acc(input int i);
`ifdef MAC_SATURATE_EN
        return (m_sum[i] > max_of(i)) ? max_of(i) : m_sum[i];
`else
        return m_sum[i] % (max_of(i) + 1);
`endif
    endfunction

    function automatic bit exp_ovf(input int i);
        return m_sum[i] > max_of(i);
    endfunction

    function automatic bit exp_rdy(input int i);
        return !m_hold[i] && (m_n[i] < len_t[i]) && !clr;
    endfunction

    function automatic void model_clear(input int i);
        m_hold[i]  = 1'b0;
        m_n[i]     = 0;
        m_added[i] = 0;
        m_sum[i]   = 0;
        m_pend[i]  = 1'b0;
        m_pprod[i] = 0;
    endfunction

    function automatic longint dut_acc(input int i);
        case (i)
            0:       return longint'(acc0);
            1:       return longint'(acc1);
            default: return longint'(acc2);
        endcase
    endfunction

    task automatic compare_all();
        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("in_ready_d%0d", i),  rdy[i], exp_rdy(i));
            check_val($sformatf("out_valid_d%0d", i), vld[i], m_hold[i]);
            check_val($sformatf("out_acc_d%0d", i),   dut_acc(i), exp_acc(i));
            check_val($sformatf("out_ovf_d%0d", i),   ovf[i], exp_ovf(i));
        end
    endtask

    // One clock cycle: drive at negedge, check, then advance the model.
    task automatic step(input bit iv, input int xx, input int yy, input bit ordy, input bit cl);
        bit acc_i [NI];
        bit hs_i  [NI];
        @(negedge clk);
        in_valid  = iv;
        x         = 4'(xx);
        y         = 4'(yy);
        out_ready = ordy;
        clr       = cl;
        #1;
        compare_all();
        for (int i = 0; i < NI; i++) begin
            acc_i[i] = iv && exp_rdy(i);
            hs_i[i]  = m_hold[i] && ordy && !cl;
            if (vld[i] && ordy && !cl) begin
                hs_cnt[i]++;
                cap_acc[i] = dut_acc(i);
                cap_ovf[i] = ovf[i];
                $display("dut%0d result acc=%0d ovf=%0b", i, dut_acc(i), ovf[i]);
            end
        end
        for (int i = 0; i < NI; i++) begin
            if (cl) begin
                model_clear(i);
            end else begin
                if (m_pend[i]) begin
                    m_sum[i] += m_pprod[i];
                    m_added[i]++;
                    m_pend[i] = 1'b0;
                    if (m_added[i] == len_t[i]) m_hold[i] = 1'b1;
                end
                if (acc_i[i]) begin
                    m_pend[i]  = 1'b1;
                    m_pprod[i] = xx * yy;
                    m_n[i]++;
                end
                if (hs_i[i]) model_clear(i);
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int k = 0; k < n; k++) step(1'b0, 0, 0, ordy, 1'b0);
    endtask

    task automatic reset_caps();
        for (int i = 0; i < NI; i++) begin
            cap_acc[i] = -1;
            cap_ovf[i] = 1'b0;
            hs_cnt[i]  = 0;
        end
    endtask

    task automatic feed_plan(input bit ordy);
        step(1'b1, 3, 5, ordy, 1'b0);
        step(1'b1, 15, 15, ordy, 1'b0);
        step(1'b1, 0, 9, ordy, 1'b0);
        step(1'b1, 7, 2, ordy, 1'b0);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;
        for (int i = 0; i < NI; i++) model_clear(i);
        reset_caps();
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("rst_valid_d%0d", i), vld[i], 1'b0);
            check_val($sformatf("rst_acc_d%0d", i), dut_acc(i), 0);
            check_val($sformatf("rst_ovf_d%0d", i), ovf[i], 1'b0);
        end
        rst = 1'b0;

        // Back-to-back terms, downstream always ready.
        reset_caps();
        feed_plan(1'b1);
        idle(4, 1'b1);
        check_val("plan_254", cap_acc[0], 254);

        // Downstream stalls 5+ cycles in HOLD.
        step(1'b0, 0, 0, 1'b0, 1'b1);
        reset_caps();
        feed_plan(1'b0);
        idle(6, 1'b0);
        idle(3, 1'b1);
        check_val("hold_254", cap_acc[0], 254);

        // Overflow on the 10-bit / 8-term instance.
        step(1'b0, 0, 0, 1'b0, 1'b1);
        reset_caps();
        for (int k = 0; k < 8; k++) step(1'b1, 15, 15, 1'b1, 1'b0);
        idle(4, 1'b1);
`ifdef MAC_SATURATE_EN
        check_val("ovf_acc", cap_acc[1], 1023);
`else
        check_val("ovf_acc", cap_acc[1], 776);
`endif
        check_val("ovf_flag", cap_ovf[1], 1'b1);

        // clr mid-accumulation; input offered during clr is refused.
        step(1'b0, 0, 0, 1'b0, 1'b1);
        reset_caps();
        step(1'b1, 4, 4, 1'b1, 1'b0);
        step(1'b1, 2, 3, 1'b1, 1'b0);
        step(1'b1, 9, 9, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b1, 1, 1, 1'b1, 1'b0);
        idle(4, 1'b1);
        check_val("clr_4", cap_acc[0], 4);

        // Asynchronous reset while holding a result.
        step(1'b0, 0, 0, 1'b0, 1'b1);
        reset_caps();
        feed_plan(1'b0);
        idle(3, 1'b0);
        check_val("pre_rst_acc", acc0, 254);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("arst_valid_d%0d", i), vld[i], 1'b0);
            check_val($sformatf("arst_acc_d%0d", i), dut_acc(i), 0);
            check_val($sformatf("arst_ovf_d%0d", i), ovf[i], 1'b0);
            model_clear(i);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) step(1'b1, 2, 2, 1'b1, 1'b0);
        idle(4, 1'b1);
        check_val("after_rst_16", cap_acc[0], 16);

        // LEN=1 with in_valid held high: one result per 3 cycles.
        step(1'b0, 0, 0, 1'b0, 1'b1);
        reset_caps();
        for (int k = 0; k < 12; k++) step(1'b1, 15, 15, 1'b1, 1'b0);
        check_val("len1_acc", cap_acc[2], 225);
        check_val("len1_count", hs_cnt[2], 4);

        // Randomized traffic.
        step(1'b0, 0, 0, 1'b0, 1'b1);
        for (int k = 0; k < 600; k++) begin
            step(($urandom % 4) != 0, int'($urandom % 16), int'($urandom % 16),
                 ($urandom % 10) < 7, ($urandom % 40) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
